wb_slave_intercon: RTL

Registered Wishbone classic single-master, multi-slave interconnect with address decode, unmapped-address error, and per-transaction timeout. It sits between the boardman UART bridge and the per-channel control slaves (biquad8 wrappers, future RFDC helpers) in the PS clock domain. It replaces the ad-hoc address-bit mux with a properly sequenced, hang-proof bus controller.

---
 rtl/wb_slave_intercon_pkg.sv | 35 +++
 rtl/wb_slave_intercon_if.sv | 37 +++
 rtl/wb_slave_intercon.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/wb_slave_intercon_pkg.sv
// Shared types for the Wishbone single-master interconnect: FSM states,
// response kinds and the address-window decoder.
package wb_intercon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        RSP_NONE,
        RSP_ACK,
        RSP_ERR,
        RSP_RTY
    } resp_t;

    typedef struct packed {
        logic       mapped;
        logic [2:0] idx;
    } decode_t;

    // Slave k owns [k<<slv_aw, (k+1)<<slv_aw); anything above the last window is unmapped.
    function automatic decode_t decode_adr(input logic [31:0] adr,
                                           input int unsigned nslv,
                                           input int unsigned slv_aw);
        logic [31:0] hi;
        decode_t     d;
        hi       = adr >> slv_aw;
        d.mapped = (hi < nslv);
        d.idx    = hi[2:0];
        return d;
    endfunction

endpackage

// File: rtl/wb_slave_intercon_if.sv
// Bus bundle between the upstream master, the interconnect and its slaves.
// The slave modport is the interconnect's view; master is the upstream side.
interface wb_slave_intercon_if #(
    parameter int NSLV   = 2,
    parameter int AW     = 22,
    parameter int SLV_AW = 7,
    parameter int DW     = 32
);
    logic                 wb_cyc_i, wb_stb_i, wb_we_i;
    logic [AW-1:0]        wb_adr_i;
    logic [DW-1:0]        wb_dat_i;
    logic [DW/8-1:0]      wb_sel_i;
    logic                 wb_ack_o, wb_err_o, wb_rty_o;
    logic [DW-1:0]        wb_dat_o;

    logic [NSLV-1:0]      s_cyc_o;
    logic                 s_stb_o, s_we_o;
    logic [SLV_AW-1:0]    s_adr_o;
    logic [DW-1:0]        s_dat_o;
    logic [DW/8-1:0]      s_sel_o;
    logic [NSLV-1:0]      s_ack_i, s_err_i, s_rty_i;
    logic [NSLV*DW-1:0]   s_dat_i;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  s_ack_i, s_err_i, s_rty_i, s_dat_i,
        output wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output s_ack_i, s_err_i, s_rty_i, s_dat_i,
        input  wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
    );
endinterface

// File: rtl/wb_slave_intercon.sv
// Registered Wishbone classic interconnect: one master, NSLV slave windows,
// unmapped-address error and a per-transaction timeout that forces an error.
module wb_slave_intercon
    import wb_intercon_pkg::*;
#(
    parameter int NSLV    = 2,
    parameter int AW      = 22,
    parameter int SLV_AW  = 7,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rstn_i,
    wb_slave_intercon_if.slave   bus,
    output logic                 timeout_o,
    output logic [15:0]          timeout_cnt_o
);

    state_t              state_q, state_d;
    logic [SLV_AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]       dat_q, dat_d;
    logic                we_q, we_d;
    logic [DW/8-1:0]     sel_q, sel_d;
    logic [NSLV-1:0]     cyc_q, cyc_d;
    logic                stb_q, stb_d;
    logic                ack_q, ack_d, err_q, err_d, rty_q, rty_d;
    logic [DW-1:0]       rdat_q, rdat_d;
    logic                tmo_q, tmo_d;
    logic [15:0]         tcnt_q, tcnt_d;
    logic [15:0]         cnt_q, cnt_d;

    decode_t             dec;
    resp_t               rsp;
    logic [DW-1:0]       slv_dat;

    // cyc_q is one-hot, so masking with it ignores every non-selected slave.
    always_comb begin
        rsp     = RSP_NONE;
        slv_dat = '0;
        if (|(bus.s_err_i & cyc_q))      rsp = RSP_ERR;
        else if (|(bus.s_rty_i & cyc_q)) rsp = RSP_RTY;
        else if (|(bus.s_ack_i & cyc_q)) rsp = RSP_ACK;
        for (int k = 0; k < NSLV; k++) begin
            if (cyc_q[k]) slv_dat = bus.s_dat_i[k*DW +: DW];
        end
    end

    always_comb begin
        // NOTE: every _d gets a default before the case so no path can infer a latch.
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        we_d    = we_q;
        sel_d   = sel_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rty_d   = 1'b0;
        rdat_d  = rdat_q;
        tmo_d   = 1'b0;
        tcnt_d  = tcnt_q;
        cnt_d   = cnt_q;
        dec     = decode_adr(32'(bus.wb_adr_i), NSLV, SLV_AW);

        case (state_q)
            ST_IDLE: begin
                if (bus.wb_cyc_i && bus.wb_stb_i) begin
                    adr_d = bus.wb_adr_i[SLV_AW-1:0];
                    dat_d = bus.wb_dat_i;
                    we_d  = bus.wb_we_i;
                    sel_d = bus.wb_sel_i;
                    if (dec.mapped) begin
                        cyc_d   = NSLV'(1) << dec.idx;
                        stb_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_ACTIVE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ACTIVE: begin
                if (!bus.wb_cyc_i) begin
                    cyc_d   = '0;
                    stb_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (rsp != RSP_NONE) begin
                    cyc_d   = '0;
                    stb_d   = 1'b0;
                    ack_d   = (rsp == RSP_ACK);
                    err_d   = (rsp == RSP_ERR);
                    rty_d   = (rsp == RSP_RTY);
                    if (!we_q) rdat_d = slv_dat;
                    state_d = ST_RESP;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    cyc_d   = '0;
                    stb_d   = 1'b0;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    if (tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            // The master still holds stb while it sees the response; skip a cycle.
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            cyc_q   <= '0;
            stb_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rty_q   <= 1'b0;
            rdat_q  <= '0;
            tmo_q   <= 1'b0;
            tcnt_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rty_q   <= rty_d;
            rdat_q  <= rdat_d;
            tmo_q   <= tmo_d;
            tcnt_q  <= tcnt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.s_cyc_o    = cyc_q;
    assign bus.s_stb_o    = stb_q;
    assign bus.s_we_o     = we_q;
    assign bus.s_adr_o    = adr_q;
    assign bus.s_dat_o    = dat_q;
    assign bus.s_sel_o    = sel_q;
    assign bus.wb_ack_o   = ack_q;
    assign bus.wb_err_o   = err_q;
    assign bus.wb_rty_o   = rty_q;
    assign bus.wb_dat_o   = rdat_q;
    assign timeout_o      = tmo_q;
    assign timeout_cnt_o  = tcnt_q;

endmodule
